// File: rtl/apb_slave_regfile.sv
// APB4 completer: DEPTH-word register file with byte strobes, programmable
// wait states, a read-only ID word at index 0 and PSLVERR on bad accesses.
module apb_slave_regfile #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 8,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_WIDTH-1:0]     paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(NB - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]            WAIT_L   = 4'(WAIT_CYCLES);
  localparam logic [DATA_WIDTH-1:0] ID_WORD  = ID_VALUE[DATA_WIDTH-1:0];

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  commit;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Decode of the live bus, used only at the setup edge.
  logic [ADDR_WIDTH-1:0] idx_full;
  logic [IDX_W-1:0]      setup_idx;
  logic                  setup_err;
  logic [DATA_WIDTH-1:0] setup_rdata;
  logic [DATA_WIDTH-1:0] access_rdata;
  logic [DATA_WIDTH-1:0] cur_word;
  logic [DATA_WIDTH-1:0] merged_word;

  assign idx_full  = paddr >> OFF_W;
  assign setup_idx = idx_full[IDX_W-1:0];
  assign setup_err = ((paddr & OFF_MASK) != '0)
                  || ({1'b0, idx_full} >= DEPTH_L)
                  || (pwrite && (idx_full == '0));

  // Writes and erroring transfers present zero on prdata.
  assign setup_rdata  = (setup_err || pwrite) ? '0 :
                        (setup_idx == '0) ? ID_WORD : mem_q[setup_idx];
  assign access_rdata = (err_q || write_q) ? '0 :
                        (idx_q == '0) ? ID_WORD : mem_q[idx_q];

  assign cur_word = mem_q[idx_q];

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign merged_word[gi*8 +: 8] = pstrb[gi] ? pwdata[gi*8 +: 8] : cur_word[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    err_d     = err_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    commit    = 1'b0;

    case (state_q)
      IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        if (psel && !penable) begin
          state_d = ACCESS;
          idx_d   = setup_idx;
          write_d = pwrite;
          err_d   = setup_err;
          cnt_d   = WAIT_L;
          if (WAIT_L == 4'd0) begin
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            prdata_d  = setup_rdata;
          end
        end
      end
      default: begin
        if (!psel) begin
          // Master abort: drop the transfer silently.
          state_d   = IDLE;
          cnt_d     = 4'd0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = access_rdata;
          end
        end else if (pready_q && penable) begin
          commit    = write_q && !err_q;
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Word 0 is never written; its read value comes from ID_WORD.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else if (commit) begin
      mem_q[idx_q] <= merged_word;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: two instances (0 and 3 wait states)
// share one APB bus; a monitor checks every pready cycle against expectations.
module tb_apb_slave_regfile;

  localparam logic [31:0] ID = 32'hA5B0_0001;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = 8'h00;
  logic [31:0] pwdata = 32'h0;
  logic [3:0]  pstrb = 4'h0;
  logic        sel_dut = 1'b0;

  logic        psel_a, psel_b;
  logic [31:0] prdata_a, prdata_b, prdata;
  logic        pready_a, pready_b, pready;
  logic        pslverr_a, pslverr_b, pslverr;

  assign psel_a  = psel && !sel_dut;
  assign psel_b  = psel && sel_dut;
  assign prdata  = sel_dut ? prdata_b  : prdata_a;
  assign pready  = sel_dut ? pready_b  : pready_a;
  assign pslverr = sel_dut ? pslverr_b : pslverr_a;

  apb_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_CYCLES(0), .ID_VALUE(ID)) u_dut0 (
    .clk(clk), .rstn(rstn), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a)
  );

  apb_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_CYCLES(3), .ID_VALUE(ID)) u_dut3 (
    .clk(clk), .rstn(rstn), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        err;
    logic [7:0]  addr;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl [2][16];
  int          tests = 0;
  int          fails = 0;

  // Monitor: one pop per cycle in which the selected slave shows pready.
  initial begin
    forever begin
      @(negedge clk);
      if (pready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pready: got pready=1 at cycle %0d, required no transfer pending", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (cyc != e.cyc || pslverr !== e.err || (e.rd && prdata !== e.data)) begin
            fails++;
            $display("FAIL xfer_%s_%02h: got cyc=%0d err=%0b data=%08h, required cyc=%0d err=%0b data=%08h",
                     e.rd ? "rd" : "wr", e.addr, cyc, pslverr, prdata, e.cyc, e.err, e.data);
          end else begin
            $display("[TB] %s addr=%02h data=%08h err=%0b cyc=%0d ok",
                     e.rd ? "RD" : "WR", e.addr, prdata, pslverr, cyc);
          end
        end
      end
    end
  end

  // Called right after a rising edge; returns right after the completing edge.
  task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    int   idx;
    logic er;
    logic done;
    idx = int'(a) / 4;
    er  = (a[1:0] != 2'b00) || (idx >= 16) || (w && idx == 0);
    e.rd   = !w;
    e.err  = er;
    e.addr = a;
    e.cyc  = cyc + 1 + (sel_dut ? 3 : 0);
    e.data = 32'h0;
    if (!w && !er) begin
      if (idx == 0) e.data = ID;
      else          e.data = mdl[sel_dut][idx];
    end
    if (w && !er) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mdl[sel_dut][idx][b*8 +: 8] = d[b*8 +: 8];
      end
    end
    exp_q.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (pready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL timeout_%02h: got no pready within 40 cycles, required completion", a);
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    tests++;
    if (pready_a !== 1'b0 || pslverr_a !== 1'b0 || prdata_a !== 32'h0 ||
        pready_b !== 1'b0 || pslverr_b !== 1'b0 || prdata_b !== 32'h0) begin
      fails++;
      $display("FAIL %s: got a=%0b/%0b/%08h b=%0b/%0b/%08h, required all zero", name,
               pready_a, pslverr_a, prdata_a, pready_b, pslverr_b, prdata_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    for (int m = 0; m < 2; m++)
      for (int w = 0; w < 16; w++) mdl[m][w] = 32'h0;

    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_state");
    @(posedge clk); #1;

    // Basic write/read, zero wait states.
    sel_dut = 1'b0;
    xfer(1'b1, 8'h04, 32'h1122_3344, 4'hF);
    xfer(1'b0, 8'h04, 32'h0, 4'h0);
    // Strobes.
    xfer(1'b1, 8'h08, 32'hFFFF_FFFF, 4'hF);
    xfer(1'b1, 8'h08, 32'h0000_0000, 4'b0101);
    xfer(1'b0, 8'h08, 32'h0, 4'h0);
    xfer(1'b1, 8'h08, 32'hDEAD_BEEF, 4'h0);
    xfer(1'b0, 8'h08, 32'h0, 4'h0);
    // Errors.
    xfer(1'b1, 8'h00, 32'h1234_5678, 4'hF);
    xfer(1'b1, 8'h41, 32'h1234_5678, 4'hF);
    xfer(1'b0, 8'h40, 32'h0, 4'h0);
    xfer(1'b0, 8'h06, 32'h0, 4'h0);
    xfer(1'b0, 8'h00, 32'h0, 4'h0);
    xfer(1'b0, 8'h04, 32'h0, 4'h0);
    // Back-to-back alternating write/read.
    for (int i = 1; i < 16; i += 2) begin
      a = 8'(i * 4);
      xfer(1'b1, a, $urandom, 4'hF);
      xfer(1'b0, a, 32'h0, 4'h0);
    end

    // Three wait states: ID read and a seed value at 0x0C.
    @(posedge clk); #1;
    sel_dut = 1'b1;
    xfer(1'b0, 8'h00, 32'h0, 4'h0);
    xfer(1'b1, 8'h0C, 32'hCAFE_F00D, 4'hF);
    xfer(1'b1, 8'h10, 32'h0BAD_0BAD, 4'hF);

    // Abort after one wait cycle.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h5555_AAAA; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    xfer(1'b0, 8'h0C, 32'h0, 4'h0);

    // Randomised mix across both slaves.
    for (int i = 0; i < 60; i++) begin
      sel_dut = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 7) a = {2'b00, 4'($urandom_range(0, 15)), 2'b00};
      else                          a = 8'($urandom_range(0, 255));
      xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end

    // Reset in the middle of a waited write.
    sel_dut = 1'b1;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h14; pwdata = 32'h7777_7777; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #3 rstn = 1'b0;
    #1;
    check_idle_outputs("reset_midwait");
    psel = 1'b0; penable = 1'b0;
    for (int m = 0; m < 2; m++)
      for (int w = 0; w < 16; w++) mdl[m][w] = 32'h0;
    @(posedge clk); #2 rstn = 1'b1;
    @(posedge clk); #1;
    for (int m = 0; m < 2; m++) begin
      sel_dut = 1'(m);
      for (int w = 0; w < 16; w++) xfer(1'b0, 8'(w * 4), 32'h0, 4'h0);
    end

    repeat (6) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

Parametrised APB4 completer: a DEPTH-word register file with byte strobes, programmable wait states, a read-only ID word and PSLVERR on bad accesses. It is the next-generation register/memory slave on the team's APB bus. It hangs off the APB bridge or test master like any other completer. It replaces the fixed zero-wait, no-error 8-bit slave.

## Interface
- DATA_WIDTH, 32: data bus width; multiple of 8; 8, 16 or 32.
- ADDR_WIDTH, 8: byte address width.
- DEPTH, 16: number of DATA_WIDTH words; 2..2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- WAIT_CYCLES, 0: wait states inserted in every access phase; 0..15.
- ID_VALUE, 32'hA5B0_0001: constant returned by word 0, truncated to DATA_WIDTH.
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- psel  in  1  slave select.
- penable  in  1  access phase marker.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  write byte strobes; ignored on reads.
- prdata  out  DATA_WIDTH  read data; valid only while pready=1 on a read.
- pready  out  1  transfer-complete indication.
- pslverr  out  1  error response; valid only while pready=1.

## Operation
- Word index = paddr >> log2(DATA_WIDTH/8). Byte offset = paddr low bits.
- Error (err) conditions:
  - byte offset != 0 (misaligned);
  - word index >= DEPTH;
  - write to word 0.
- Word 0 is read-only and always reads ID_VALUE. Words 1..DEPTH-1 are read/write storage.
- FSM, two states:
  - IDLE: psel=1 and penable=0 (setup phase) -> latch paddr, pwrite, err; load wait counter with WAIT_CYCLES; go to ACCESS. Any other input keeps IDLE.
  - ACCESS: counter != 0 -> decrement. Counter == 0 -> pready=1. An edge with psel=1, penable=1, pready=1 completes the transfer; next state is IDLE.
  - ACCESS with psel=0 (master abort) -> IDLE. No write, no error flagged.
- Write commit: at the completing edge, if !err. Byte lane i of the word is updated only if pstrb[i]=1. pstrb=0 is a legal no-op write.
- Read: prdata is loaded at the edge on which the counter reaches 0, or at the setup edge when WAIT_CYCLES=0. Loaded value: the addressed word; ID_VALUE for word 0; 0 if err.
- pslverr=1 alongside pready only for err transfers. An erroring write never modifies storage.
- Address and control are taken from the setup-phase latch. Changes to paddr or pwrite during the access phase are ignored.

## Timing
- Reset values: pready=0, pslverr=0, prdata=0, state=IDLE, counter=0, all storage words=0.
- Reset asserted mid-transfer: immediate return to these values; any pending write is lost.
- Outputs are registered. pready, pslverr and prdata change only on clk edges or on reset.
- Latency: setup cycle, then WAIT_CYCLES cycles with pready=0, then one cycle with pready=1. Total transfer = WAIT_CYCLES+2 cycles.
- In IDLE: pready=0 and pslverr=0. prdata returns to 0 on the edge that enters IDLE.
- Back-to-back transfers: a setup phase on the cycle right after completion is accepted with no idle gap.
- A write followed immediately by a read of the same word returns the new data.
- A penable=1 seen in IDLE without a preceding setup is ignored; the slave stays in IDLE.

## Test plan
- Reset, then WAIT_CYCLES=0 write 0x1122_3344 to paddr 0x04 with pstrb=4'hF, then read 0x04 -> each transfer takes 2 cycles; read returns 0x1122_3344; pslverr=0.
- Strobes: write 0xFFFF_FFFF to 0x08, then write 0x0000_0000 with pstrb=4'b0101, then read 0x08 -> 0xFF00_FF00.
- WAIT_CYCLES=3, read 0x00 -> pready low for 3 access cycles, then high one cycle; prdata=0xA5B0_0001; pslverr=0.
- Errors: write to 0x00, write to 0x41 (misaligned), read 0x40 (index 16 >= DEPTH) -> pslverr=1 with pready each time; reads return prdata=0; re-reading words 0 and 1 shows no change.
- Abort and reset: WAIT_CYCLES=3 write to 0x0C, drop psel after 1 wait cycle -> IDLE, word unchanged. Then assert rstn=0 mid-wait of a second write -> outputs 0 immediately; all words read back 0.
- Back-to-back: 8 consecutive alternating write/read transfers to 0x04..0x3C with no idle cycles -> every read matches the preceding write; no transfer is dropped.
